// File: rtl/alu_issue_sequencer_if.sv
// Request and result handshake bundle for the ALU issue sequencer.
// master: the upstream producer / result consumer; slave: the sequencer.
interface alu_issue_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;

    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_c;
    logic [2:0] res_flags;
    logic [2:0] res_op;
    logic       res_err;

    modport master (
        output in_valid, in_op, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_c, res_flags, res_op, res_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, res_ready,
        output in_ready, res_valid, res_c, res_flags, res_op, res_err
    );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Feeds requests from a small FIFO to the 4-bit bit-serial ALU, holding each
// operation for OP_CYCLES cycles, then captures the ALU outputs into a result
// register with its own valid/ready handshake.
module alu_issue_sequencer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned OP_CYCLES = 5,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_issue_sequencer_if.slave bus,
    output logic [2:0]           alu_opcode,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    input  logic [3:0]           alu_c,
    input  logic                 alu_carry,
    input  logic                 alu_sign,
    input  logic                 alu_zero,
    output logic                 busy,
    output logic [CNT_W-1:0]     fifo_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CTR_W = $clog2(OP_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

    // FIFO entry: {op, a, b}
    logic [10:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop;
    logic [2:0]       head_op;
    logic [3:0]       head_a, head_b;

    state_e           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [2:0]       op_q;
    logic [3:0]       a_q, b_q;
    logic             load_alu, load_err, load_cap;

    logic             res_valid_q;
    logic [3:0]       res_c_q;
    logic [2:0]       res_flags_q, res_op_q;
    logic             res_err_q;
    logic             res_free;

    assign bus.in_ready = (count_q != CNT_W'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    assign {head_op, head_a, head_b} = mem_q[rd_ptr_q];

    // Result slot can take a new value if empty or being drained this cycle
    assign res_free = !res_valid_q || bus.res_ready;

    // FIFO storage, no reset needed: only read behind a valid count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_op, bus.in_a, bus.in_b};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
        end
    end

    // Issue FSM next-state and control strobes
    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        pop      = 1'b0;
        load_alu = 1'b0;
        load_err = 1'b0;
        load_cap = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0 && res_free) begin
                    pop = 1'b1;
                    if (head_op inside {3'b001, 3'b010, 3'b011, 3'b100}) begin
                        load_alu = 1'b1;
                        ctr_d    = '0;
                        state_d  = StIssue;
                    end else begin
                        load_err = 1'b1;
                    end
                end
            end
            StIssue: begin
                ctr_d = ctr_q + CTR_W'(1);
                if (ctr_q == CTR_W'(OP_CYCLES - 1)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                load_cap = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, issue counter and held ALU operands
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ctr_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            if (load_alu) begin
                op_q <= head_op;
                a_q  <= head_a;
                b_q  <= head_b;
            end
        end
    end

    // Result register: drain on ready, a same-cycle load wins over the drain
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_c_q     <= '0;
            res_flags_q <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
        end else if (load_err) begin
            res_valid_q <= 1'b1;
            res_c_q     <= '0;
            res_flags_q <= '0;
            res_op_q    <= head_op;
            res_err_q   <= 1'b1;
        end else if (load_cap) begin
            res_valid_q <= 1'b1;
            res_c_q     <= alu_c;
            res_flags_q <= {alu_carry, alu_sign, alu_zero};
            res_op_q    <= op_q;
            res_err_q   <= 1'b0;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    // Opcode only during ISSUE so the ALU sees 000 gaps between operations
    always_comb begin
        alu_opcode = (state_q == StIssue) ? op_q : 3'b000;
        alu_a      = a_q;
        alu_b      = b_q;
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_c     = res_c_q;
    assign bus.res_flags = res_flags_q;
    assign bus.res_op    = res_op_q;
    assign bus.res_err   = res_err_q;
    assign busy          = (state_q != StIdle);
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed self-checking bench for alu_issue_sequencer with a behavioural
// bit-serial ALU stand-in that updates its outputs while an opcode is driven.
module tb_alu_issue_sequencer;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned OP_CYCLES = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] alu_opcode;
    logic [3:0] alu_a, alu_b;
    logic [3:0] alu_c = '0;
    logic       alu_carry = 1'b0, alu_sign = 1'b0, alu_zero = 1'b0;
    logic       busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_sequencer_if bus ();

    alu_issue_sequencer #(
        .DEPTH     (DEPTH),
        .OP_CYCLES (OP_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .alu_carry  (alu_carry),
        .alu_sign   (alu_sign),
        .alu_zero   (alu_zero),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // ALU stand-in: {carry, c}; sub is a + ~b + 1
    function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        case (op)
            3'b001:  return {1'b0, a ^ b};
            3'b010:  return {1'b0, a} + {1'b0, b};
            3'b011:  return {1'b0, a & b};
            3'b100:  return {1'b0, a} + {1'b0, ~b} + 5'd1;
            default: return 5'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [4:0] r;
        if (alu_opcode != 3'b000) begin
            r = alu_fn(alu_opcode, alu_a, alu_b);
            alu_c     <= r[3:0];
            alu_carry <= r[4];
            alu_sign  <= r[3];
            alu_zero  <= (r[3:0] == 4'd0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one request into an empty, idle sequencer and follow it to its result
    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] exp_c,
                          input logic [2:0] exp_flags, input logic exp_err, input int exp_lat);
        int k;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        k = 0;
        while (k < 30) begin
            tick();
            k++;
            if (k == 1) check({tag, "_alu_op"}, alu_opcode, exp_err ? 3'b000 : op);
            if (bus.res_valid) break;
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_c"}, bus.res_c, exp_c);
        check({tag, "_flags"}, bus.res_flags, exp_flags);
        check({tag, "_op"}, bus.res_op, op);
        check({tag, "_err"}, bus.res_err, exp_err);
    endtask

    logic [2:0] q_op    [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010, 3'b010};
    logic [3:0] q_a     [6] = '{4'b0001, 4'b1111, 4'b1111, 4'b0101, 4'b1000, 4'b0111};
    logic [3:0] q_b     [6] = '{4'b0010, 4'b0001, 4'b0101, 4'b0011, 4'b1000, 4'b0001};
    logic [3:0] q_c     [6] = '{4'b0011, 4'b1110, 4'b0101, 4'b0010, 4'b0000, 4'b1000};
    logic [2:0] q_flags [6] = '{3'b000, 3'b010, 3'b000, 3'b100, 3'b101, 3'b010};

    initial begin
        int got;
        int cyc;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_alu_op", alu_opcode, 3'b000);
        check("rst_alu_a", alu_a, 4'd0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_res_c", bus.res_c, 4'd0);
        check("rst_res_flags", bus.res_flags, 3'd0);
        check("rst_res_op", bus.res_op, 3'd0);
        check("rst_res_err", bus.res_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", fifo_count, 3'd0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Legal operations, results drained immediately
        bus.res_ready = 1'b1;
        run_op("add", 3'b010, 4'b0101, 4'b0011, 4'b1000, 3'b010, 1'b0, OP_CYCLES + 2);
        tick();
        check("add_drained", bus.res_valid, 1'b0);
        run_op("sub", 3'b100, 4'b0011, 4'b0011, 4'b0000, 3'b101, 1'b0, OP_CYCLES + 2);
        tick();
        run_op("xor", 3'b001, 4'b1010, 4'b0110, 4'b1100, 3'b010, 1'b0, OP_CYCLES + 2);
        tick();
        run_op("and", 3'b011, 4'b0110, 4'b0011, 4'b0010, 3'b000, 1'b0, OP_CYCLES + 2);
        tick();

        // Illegal opcode: no ALU issue, error result one cycle after the pop
        bus.res_ready = 1'b0;
        run_op("ill", 3'b111, 4'b1111, 4'b1111, 4'b0000, 3'b000, 1'b1, 1);
        check("ill_busy", busy, 1'b0);
        bus.res_ready = 1'b1;
        tick();
        check("ill_drained", bus.res_valid, 1'b0);

        // Backpressure: held result stays stable, sequencer idles
        bus.res_ready = 1'b0;
        run_op("bp", 3'b010, 4'b0111, 4'b0110, 4'b1101, 3'b010, 1'b0, OP_CYCLES + 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", bus.res_valid, 1'b1);
            check("bp_c", bus.res_c, 4'b1101);
            check("bp_flags", bus.res_flags, 3'b010);
            check("bp_busy", busy, 1'b0);
        end
        bus.res_ready = 1'b1;
        tick();
        check("bp_drained", bus.res_valid, 1'b0);

        // FIFO full: five accepted, sixth held, results in push order
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = q_op[i];
            bus.in_a     = q_a[i];
            bus.in_b     = q_b[i];
            check("full_accept", bus.in_ready, 1'b1);
            tick();
        end
        bus.in_op = q_op[5];
        bus.in_a  = q_a[5];
        bus.in_b  = q_b[5];
        check("full_count", fifo_count, 3'd4);
        check("full_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("full_first_res", bus.res_valid, 1'b1);
        check("full_no_issue", alu_opcode, 3'b000);
        check("full_busy", busy, 1'b0);
        check("full_count_hold", fifo_count, 3'd4);
        check("full_held", bus.in_ready, 1'b0);
        bus.res_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 200) begin
            if (bus.res_valid) begin
                check("full_res_c", bus.res_c, q_c[got]);
                check("full_res_flags", bus.res_flags, q_flags[got]);
                check("full_res_op", bus.res_op, q_op[got]);
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                tick();
                bus.in_valid = 1'b0;
            end else begin
                tick();
            end
            cyc++;
        end
        check("full_res_count", got, 6);
        check("full_empty", fifo_count, 3'd0);

        // Reset mid-issue with three requests queued
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = q_op[i];
            bus.in_a     = q_a[i];
            bus.in_b     = q_b[i];
            tick();
        end
        bus.in_valid = 1'b0;
        check("mid_busy", busy, 1'b1);
        check("mid_count", fifo_count, 3'd3);
        check("mid_alu_op", alu_opcode, 3'b010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_alu_op", alu_opcode, 3'b000);
        check("mid_rst_count", fifo_count, 3'd0);
        check("mid_rst_res_valid", bus.res_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        tick();
        run_op("post_rst", 3'b010, 4'b0001, 4'b0001, 4'b0010, 3'b000, 1'b0, OP_CYCLES + 2);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
